// File: rtl/prbs_ber_checker.sv
// PRBS9 bit-error-rate checker.
// Picks one sample per symbol from an oversampled signed stream and slices it
// to a bit. A local x^9+x^5+1 reference self-synchronises to the incoming bits.
// The block reports lock, per-bit error pulses and saturating bit/error counts.
module prbs_ber_checker #(
    parameter int NB_DATA  = 13,
    parameter int NB_PHASE = 3,
    parameter int NB_CNT   = 32,
    parameter int NB_WIN   = 10,
    parameter int ERR_THR  = 64,
    parameter int SYNC_LEN = 32
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic signed [NB_DATA-1:0]  i_sample,
    input  logic [NB_PHASE-1:0]        i_phase,
    input  logic                       i_clear,
    output logic                       o_lock,
    output logic                       o_bit,
    output logic                       o_bit_valid,
    output logic                       o_err,
    output logic [NB_CNT-1:0]          o_bit_count,
    output logic [NB_CNT-1:0]          o_err_count
);

    localparam int NB_MATCH = $clog2(SYNC_LEN + 1);
    localparam int NB_WERR  = $clog2(ERR_THR + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [8:0]          lfsr_q, lfsr_d;
    logic [NB_PHASE-1:0] phase_q, phase_d;
    logic [NB_MATCH-1:0] match_q, match_d;
    logic [NB_WIN-1:0]   win_sym_q, win_sym_d;
    logic [NB_WERR-1:0]  win_err_q, win_err_d;
    logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
    logic                bit_q, bit_d;
    logic                bit_valid_q, bit_valid_d;
    logic                err_q, err_d;

    logic                decide;
    logic                rx;
    logic                pred;
    logic                mismatch;
    logic [NB_WERR-1:0]  win_err_nxt;

    // Only the sign bit drives the decision; magnitude bits are intentionally dropped.
    logic unused_sample_bits;
    assign unused_sample_bits = ^i_sample[NB_DATA-2:0];

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [NB_WERR-1:0] sat_win_err(input logic [NB_WERR-1:0] v);
        return (v >= NB_WERR'(ERR_THR)) ? v : v + 1'b1;
    endfunction

    assign decide   = i_valid && (phase_q == i_phase);
    assign rx       = i_sample[NB_DATA-1];
    assign pred     = lfsr_q[8] ^ lfsr_q[4];
    assign mismatch = (rx != pred);

    // State registers; reset restores the full power-up state.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q     <= SEARCH;
            lfsr_q      <= '0;
            phase_q     <= '0;
            match_q     <= '0;
            win_sym_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            phase_q     <= phase_d;
            match_q     <= match_d;
            win_sym_q   <= win_sym_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state: phase tracking, bit decision, sync FSM, counters and window monitor.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        phase_d     = phase_q;
        match_d     = match_q;
        win_sym_d   = win_sym_q;
        win_err_d   = win_err_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        err_d       = 1'b0;
        win_err_nxt = win_err_q;

        if (i_enable) begin
            if (i_valid) begin
                phase_d = phase_q + 1'b1;
            end
            if (i_clear) begin
                bit_cnt_d = '0;
                err_cnt_d = '0;
                win_sym_d = '0;
                win_err_d = '0;
            end
            if (decide) begin
                bit_d       = rx;
                bit_valid_d = 1'b1;
                case (state_q)
                    SEARCH: begin
                        lfsr_d = {lfsr_q[7:0], rx};
                        // An all-zero register predicts zeros forever, so it never counts.
                        if (!mismatch && (lfsr_q != 9'd0)) begin
                            if (match_q == NB_MATCH'(SYNC_LEN - 1)) begin
                                state_d   = LOCKED;
                                match_d   = '0;
                                win_sym_d = '0;
                                win_err_d = '0;
                            end else begin
                                match_d = match_q + 1'b1;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running reference: a line error is not fed back.
                        lfsr_d = {lfsr_q[7:0], pred};
                        err_d  = mismatch;
                        if (!i_clear) begin
                            bit_cnt_d = sat_inc(bit_cnt_q);
                            if (mismatch) begin
                                err_cnt_d   = sat_inc(err_cnt_q);
                                win_err_nxt = sat_win_err(win_err_q);
                            end
                            if (&win_sym_q) begin
                                if (win_err_nxt >= NB_WERR'(ERR_THR)) begin
                                    state_d = SEARCH;
                                    match_d = '0;
                                end
                                win_sym_d = '0;
                                win_err_d = '0;
                            end else begin
                                win_sym_d = win_sym_q + 1'b1;
                                win_err_d = win_err_nxt;
                            end
                        end
                    end
                    default: begin
                        state_d = SEARCH;
                    end
                endcase
            end
        end
    end

    assign o_lock      = (state_q == LOCKED);
    assign o_bit       = bit_q;
    assign o_bit_valid = bit_valid_q;
    assign o_err       = err_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule
